// File: rtl/commit_trace_streamer_pkg.sv
// Shared types and beat layout for the commit trace streamer.
// Optional header beat (record sequence number) enabled by defining TRACE_HEADER_EN.
package commit_trace_streamer_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int IDX_W_DEF    = 6;

    typedef enum logic [2:0] {
        IDLE,
        SEND_HDR,
        SEND_PC,
        SEND_INST,
        SEND_REG
    } state_t;

`ifdef TRACE_HEADER_EN
    localparam int HDR_BEATS = 1;
`else
    localparam int HDR_BEATS = 0;
`endif

    localparam int IDX_PC      = HDR_BEATS;
    localparam int IDX_INST    = HDR_BEATS + 1;
    localparam int IDX_REG0    = HDR_BEATS + 2;
    localparam int TRACE_BEATS = NUM_REGS_DEF + IDX_REG0;

    // Header word is the full 32-bit record sequence number, wrapping naturally.
    typedef logic [31:0] hdr_word_t;

`ifdef TRACE_HEADER_EN
    function automatic hdr_word_t header_word(input logic [31:0] seq);
        return seq;
    endfunction
`endif

endpackage

// File: rtl/commit_trace_streamer_if.sv
// Valid/ready beat stream carrying one trace record per committed instruction.
interface commit_trace_streamer_if
    import commit_trace_streamer_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
);
    logic             tr_valid;
    logic             tr_ready;
    logic [31:0]      tr_data;
    logic [IDX_W-1:0] tr_idx;
    logic             tr_last;

    modport master (output tr_valid, tr_data, tr_idx, tr_last, input tr_ready);
    modport slave  (input tr_valid, tr_data, tr_idx, tr_last, output tr_ready);
endinterface

// File: rtl/commit_trace_streamer_commit_detect.sv
// Commit detector: tracks the last idle-cycle pc/inst and flags a new commit.
module commit_trace_streamer_commit_detect (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        idle,
    input  logic        trace_en,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic        fire,
    output logic [31:0] pc_q,
    output logic [31:0] inst_q
);
    logic        armed_reg;
    logic [31:0] pc_q_reg;
    logic [31:0] inst_q_reg;

    // Tracking continues while trace_en=0 so re-enabling never replays an old pc.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            armed_reg  <= 1'b0;
            pc_q_reg   <= '0;
            inst_q_reg <= '0;
        end else if (idle) begin
            armed_reg  <= 1'b1;
            pc_q_reg   <= pc;
            inst_q_reg <= inst;
        end
    end

    // Gated by reset so the core is never stalled while reset is held.
    assign fire   = !reset && idle && trace_en && (!armed_reg || (pc != pc_q_reg));
    assign pc_q   = pc_q_reg;
    assign inst_q = inst_q_reg;
endmodule

// File: rtl/commit_trace_streamer.sv
// Streams pc, inst and the register file as 32-bit beats on every commit, stalling the core.
// Define TRACE_HEADER_EN to prepend a record sequence-number beat.
module commit_trace_streamer
    import commit_trace_streamer_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int IDX_W    = IDX_W_DEF
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        trace_en,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        cpu_stall,
    commit_trace_streamer_if.master trace
);
    state_t           state_reg;
    state_t           state_next;
    logic             fire;
    logic             idle;
    logic             handshake;
    logic             record_done;
    logic [31:0]      pc_q;
    logic [31:0]      inst_q;
    logic [31:0]      first_word;
    logic             tr_valid_reg;
    logic             tr_last_reg;
    logic [31:0]      tr_data_reg;
    logic [IDX_W-1:0] tr_idx_reg;
    logic [4:0]       raddr_reg;

    assign idle        = (state_reg == IDLE);
    assign handshake   = tr_valid_reg && trace.tr_ready;
    assign record_done = (state_reg == SEND_REG) && handshake && tr_last_reg;
    assign cpu_stall   = fire || !idle;

    commit_trace_streamer_commit_detect u_detect (
        .clk_in   (clk_in),
        .reset    (reset),
        .idle     (idle),
        .trace_en (trace_en),
        .pc       (pc),
        .inst     (inst),
        .fire     (fire),
        .pc_q     (pc_q),
        .inst_q   (inst_q)
    );

`ifdef TRACE_HEADER_EN
    localparam state_t FIRST_STATE = SEND_HDR;
    logic [31:0] seq_reg;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            seq_reg <= '0;
        end else if (record_done) begin
            seq_reg <= seq_reg + 32'd1;
        end
    end

    assign first_word = header_word(seq_reg);
`else
    localparam state_t FIRST_STATE = SEND_PC;
    // pc_q loads this same pc on the fire edge, so beat 0 equals pc_q.
    assign first_word = pc;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (fire)        state_next = FIRST_STATE;
            SEND_HDR:  if (handshake)   state_next = SEND_PC;
            SEND_PC:   if (handshake)   state_next = SEND_INST;
            SEND_INST: if (handshake)   state_next = SEND_REG;
            SEND_REG:  if (record_done) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Each handshake loads the following beat; rf_raddr already points at the next register.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            tr_valid_reg <= 1'b0;
            tr_last_reg  <= 1'b0;
            tr_data_reg  <= '0;
            tr_idx_reg   <= '0;
            raddr_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fire) begin
                        tr_valid_reg <= 1'b1;
                        tr_last_reg  <= 1'b0;
                        tr_data_reg  <= first_word;
                        tr_idx_reg   <= '0;
                        raddr_reg    <= '0;
                    end
                end
                SEND_HDR: begin
                    if (handshake) begin
                        tr_data_reg <= pc_q;
                        tr_idx_reg  <= IDX_W'(IDX_PC);
                    end
                end
                SEND_PC: begin
                    if (handshake) begin
                        tr_data_reg <= inst_q;
                        tr_idx_reg  <= IDX_W'(IDX_INST);
                    end
                end
                SEND_INST: begin
                    if (handshake) begin
                        tr_data_reg <= rf_rdata;
                        tr_idx_reg  <= IDX_W'(IDX_REG0);
                        tr_last_reg <= (NUM_REGS == 1);
                        raddr_reg   <= 5'd1;
                    end
                end
                SEND_REG: begin
                    if (handshake) begin
                        if (tr_last_reg) begin
                            tr_valid_reg <= 1'b0;
                            tr_last_reg  <= 1'b0;
                            raddr_reg    <= '0;
                        end else begin
                            tr_data_reg <= rf_rdata;
                            tr_idx_reg  <= tr_idx_reg + IDX_W'(1);
                            tr_last_reg <= (raddr_reg == 5'(NUM_REGS - 1));
                            raddr_reg   <= raddr_reg + 5'd1;
                        end
                    end
                end
                default: begin
                    tr_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign rf_raddr       = raddr_reg;
    assign trace.tr_valid = tr_valid_reg;
    assign trace.tr_last  = tr_last_reg;
    assign trace.tr_data  = tr_data_reg;
    assign trace.tr_idx   = tr_idx_reg;
endmodule

// File: tb/tb_commit_trace_streamer.sv
// Randomized bench for commit_trace_streamer: a record-level model builds the expected beat list.
// Define TRACE_HEADER_EN for both RTL and bench to exercise the header beat.
module tb_commit_trace_streamer;

    localparam int NREGS = 32;
`ifdef TRACE_HEADER_EN
    localparam int HB = 1;
`else
    localparam int HB = 0;
`endif
    localparam int NB = NREGS + 2 + HB;

    typedef struct packed {
        logic        s;
        logic        l;
        logic [5:0]  i;
        logic [31:0] d;
    } beat_t;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        trace_en = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] inst = '0;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        cpu_stall;

    logic [31:0] rf_mem [NREGS];
    logic [31:0] rf_saved [NREGS];

    int    compared = 0;
    int    mismatched = 0;
    int    ready_mode = 0;
    int    hold_viol = 0;
    int    hold_events = 0;
    int    stall_cycles = 0;
    logic [31:0] exp_seq = '0;
    beat_t mon_q[$];
    beat_t exp_q[$];

    logic        hold_pend = 1'b0;
    logic [31:0] hold_d;
    logic [5:0]  hold_i;
    logic        hold_l;

    commit_trace_streamer_if #(.IDX_W(6)) tif ();

    commit_trace_streamer dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .trace_en (trace_en),
        .pc       (pc),
        .inst     (inst),
        .rf_raddr (rf_raddr),
        .rf_rdata (rf_rdata),
        .cpu_stall(cpu_stall),
        .trace    (tif)
    );

    assign rf_rdata = rf_mem[rf_raddr];

    initial forever #5 clk_in = ~clk_in;

    initial tif.tr_ready = 1'b1;
    always @(posedge clk_in) begin
        #1;
        case (ready_mode)
            0:       tif.tr_ready = 1'b1;
            1:       tif.tr_ready = ~tif.tr_ready;
            default: tif.tr_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Sink monitor: values read here are the pre-edge ones driving this handshake.
    always @(posedge clk_in) begin
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (cpu_stall) stall_cycles++;
            if (hold_pend) begin
                hold_events++;
                if (tif.tr_valid !== 1'b1 || tif.tr_data !== hold_d ||
                    tif.tr_idx !== hold_i || tif.tr_last !== hold_l)
                    hold_viol++;
            end
            hold_pend = tif.tr_valid && !tif.tr_ready;
            hold_d = tif.tr_data;
            hold_i = tif.tr_idx;
            hold_l = tif.tr_last;
            if (tif.tr_valid && tif.tr_ready)
                mon_q.push_back('{s: cpu_stall, l: tif.tr_last, i: tif.tr_idx, d: tif.tr_data});
        end
    end

    // Record model: optional sequence number, pc, inst, then the register file in order.
    task automatic build_expected(input logic [31:0] p, input logic [31:0] ins);
        logic [31:0] w;
        exp_q.delete();
        for (int j = 0; j < NB; j++) begin
            if (j < HB)           w = exp_seq;
            else if (j == HB)     w = p;
            else if (j == HB + 1) w = ins;
            else                  w = rf_mem[j - HB - 2];
            exp_q.push_back('{s: 1'b1, l: (j == NB - 1), i: 6'(j), d: w});
        end
        exp_seq = exp_seq + 32'd1;
    endtask

    task automatic commit(input logic [31:0] p, input logic [31:0] ins);
        build_expected(p, ins);
        mon_q.delete();
        pc = p;
        inst = ins;
    endtask

    task automatic wait_beats(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_in);
            if (mon_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        trace_en = 1'b1;
        ready_mode = 0;
        pc = 32'h00400000;
        inst = 32'h08100004;
        for (int i = 0; i < NREGS; i++) rf_mem[i] = $urandom;
        repeat (3) @(negedge clk_in);
        compared++;
        if ({tif.tr_valid, tif.tr_last, tif.tr_idx, tif.tr_data, cpu_stall, rf_raddr} !== 46'd0) begin
            mismatched++;
            $display("FAIL reset_state: valid=%b last=%b idx=%0d data=%h stall=%b raddr=%0d, expected all zero",
                     tif.tr_valid, tif.tr_last, tif.tr_idx, tif.tr_data, cpu_stall, rf_raddr);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_first_record();
        bit ok;
        for (int i = 0; i < NREGS; i++) rf_saved[i] = rf_mem[i];
        exp_seq = '0;
        commit(32'h00400000, 32'h08100004);
        reset = 1'b0;
        wait_beats(NB, ok);
        compared++;
        if (!ok || mon_q.size() != NB) begin
            mismatched++;
            $display("FAIL first_count: got %0d beats, expected %0d", mon_q.size(), NB);
        end
        for (int j = 0; j < NB && j < mon_q.size(); j++) begin
            compared++;
            if (mon_q[j] !== exp_q[j]) begin
                mismatched++;
                $display("FAIL first_beat%0d: got %h expected %h", j, mon_q[j], exp_q[j]);
            end
        end
        compared++;
        if (tif.tr_valid !== 1'b0 || cpu_stall !== 1'b0) begin
            mismatched++;
            $display("FAIL first_idle: valid=%b stall=%b, expected 0 0", tif.tr_valid, cpu_stall);
        end
        $display("first record: pc=%h %0d beats", pc, mon_q.size());
    endtask

    task automatic test_pc_step();
        bit ok;
        rf_mem[8] = 32'h0000002a;
        commit(32'h00400004, $urandom);
        wait_beats(NB, ok);
        compared++;
        if (!ok || mon_q.size() != NB) begin
            mismatched++;
            $display("FAIL step_count: got %0d beats, expected %0d", mon_q.size(), NB);
        end
        for (int j = 0; j < NB && j < mon_q.size(); j++) begin
            compared++;
            if (mon_q[j] !== exp_q[j]) begin
                mismatched++;
                $display("FAIL step_beat%0d: got %h expected %h", j, mon_q[j], exp_q[j]);
            end
        end
        if (mon_q.size() > HB + 10) begin
            compared++;
            if (mon_q[HB + 10].d !== 32'h0000002a) begin
                mismatched++;
                $display("FAIL step_reg8: got %h expected 0000002a", mon_q[HB + 10].d);
            end
        end
        $display("pc step: pc=%h %0d beats", pc, mon_q.size());
    endtask

    task automatic test_ready_toggle();
        bit ok;
        int hv0, he0;
        for (int i = 0; i < NREGS; i++) rf_mem[i] = rf_saved[i];
        hv0 = hold_viol;
        he0 = hold_events;
        ready_mode = 1;
        commit(32'h00400000, 32'h08100004);
        wait_beats(NB, ok);
        ready_mode = 0;
        compared++;
        if (!ok || mon_q.size() != NB) begin
            mismatched++;
            $display("FAIL toggle_count: got %0d beats, expected %0d", mon_q.size(), NB);
        end
        for (int j = 0; j < NB && j < mon_q.size(); j++) begin
            compared++;
            if (mon_q[j] !== exp_q[j]) begin
                mismatched++;
                $display("FAIL toggle_beat%0d: got %h expected %h", j, mon_q[j], exp_q[j]);
            end
        end
        compared++;
        if (hold_viol - hv0 != 0 || hold_events - he0 < 8) begin
            mismatched++;
            $display("FAIL toggle_hold: %0d changes while stalled over %0d stalls, expected 0 over >=8",
                     hold_viol - hv0, hold_events - he0);
        end
        $display("ready toggle: %0d beats, %0d stalled cycles", mon_q.size(), hold_events - he0);
    endtask

    task automatic test_trace_enable();
        bit ok;
        int st0;
        @(negedge clk_in);
        trace_en = 1'b0;
        mon_q.delete();
        st0 = stall_cycles;
        for (int k = 0; k < 3; k++) begin
            pc = 32'h00500000 + 32'(k * 4);
            inst = $urandom;
            repeat (5) @(negedge clk_in);
        end
        trace_en = 1'b1;
        pc = pc;
        repeat (8) @(negedge clk_in);
        compared++;
        if (mon_q.size() != 0 || stall_cycles != st0) begin
            mismatched++;
            $display("FAIL enable_quiet: got %0d beats %0d stall cycles, expected 0 0",
                     mon_q.size(), stall_cycles - st0);
        end
        commit(32'h00500100, $urandom);
        wait_beats(NB, ok);
        repeat (10) @(negedge clk_in);
        compared++;
        if (!ok || mon_q.size() != NB) begin
            mismatched++;
            $display("FAIL enable_count: got %0d beats, expected %0d", mon_q.size(), NB);
        end
        for (int j = 0; j < NB && j < mon_q.size(); j++) begin
            compared++;
            if (mon_q[j] !== exp_q[j]) begin
                mismatched++;
                $display("FAIL enable_beat%0d: got %h expected %h", j, mon_q[j], exp_q[j]);
            end
        end
        $display("trace enable: %0d beats after re-enable", mon_q.size());
    endtask

    task automatic test_reset_mid_record();
        bit ok;
        commit(32'h00600000, $urandom);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk_in);
            if (tif.tr_valid === 1'b1 && tif.tr_idx === 6'd12) begin
                ok = 1'b1;
                break;
            end
        end
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL midreset_reach: beat idx12 not presented, expected it within 300 cycles");
        end
        reset = 1'b1;
        @(negedge clk_in);
        compared++;
        if (tif.tr_valid !== 1'b0 || cpu_stall !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_abort: valid=%b stall=%b, expected 0 0", tif.tr_valid, cpu_stall);
        end
        compared++;
        if ({tif.tr_last, tif.tr_idx, tif.tr_data, rf_raddr} !== 44'd0) begin
            mismatched++;
            $display("FAIL midreset_outputs: last=%b idx=%0d data=%h raddr=%0d, expected zeros",
                     tif.tr_last, tif.tr_idx, tif.tr_data, rf_raddr);
        end
        exp_seq = '0;
        commit(32'h00600040, $urandom);
        @(negedge clk_in);
        reset = 1'b0;
        wait_beats(NB, ok);
        compared++;
        if (!ok || mon_q.size() != NB) begin
            mismatched++;
            $display("FAIL midreset_count: got %0d beats, expected %0d", mon_q.size(), NB);
        end
        for (int j = 0; j < NB && j < mon_q.size(); j++) begin
            compared++;
            if (mon_q[j] !== exp_q[j]) begin
                mismatched++;
                $display("FAIL midreset_beat%0d: got %h expected %h", j, mon_q[j], exp_q[j]);
            end
        end
        $display("reset mid-record: restart pc=%h %0d beats", pc, mon_q.size());
    endtask

    task automatic test_random_records();
        bit ok;
        logic [31:0] p;
        int hv0;
        hv0 = hold_viol;
        ready_mode = 2;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NREGS; i++) rf_mem[i] = $urandom;
            p = $urandom & 32'hfffffffc;
            if (p == pc) p = p + 32'd4;
            commit(p, $urandom);
            wait_beats(NB, ok);
            compared++;
            if (!ok || mon_q.size() != NB) begin
                mismatched++;
                $display("FAIL random%0d_count: got %0d beats, expected %0d", r, mon_q.size(), NB);
            end
            for (int j = 0; j < NB && j < mon_q.size(); j++) begin
                compared++;
                if (mon_q[j] !== exp_q[j]) begin
                    mismatched++;
                    $display("FAIL random%0d_beat%0d: got %h expected %h", r, j, mon_q[j], exp_q[j]);
                end
            end
            compared++;
            if (tif.tr_valid !== 1'b0 || cpu_stall !== 1'b0) begin
                mismatched++;
                $display("FAIL random%0d_idle: valid=%b stall=%b, expected 0 0", r, tif.tr_valid, cpu_stall);
            end
            $display("random record %0d: pc=%h %0d beats", r, p, mon_q.size());
        end
        ready_mode = 0;
        compared++;
        if (hold_viol - hv0 != 0) begin
            mismatched++;
            $display("FAIL random_hold: %0d payload changes while stalled, expected 0", hold_viol - hv0);
        end
    endtask

`ifdef TRACE_HEADER_EN
    task automatic test_header();
        bit ok;
        reset = 1'b1;
        @(negedge clk_in);
        exp_seq = '0;
        commit(32'h00700000, $urandom);
        @(negedge clk_in);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) commit(32'h00700000 + 32'(k * 4), $urandom);
            wait_beats(NB, ok);
            compared++;
            if (!ok || mon_q.size() != NB || mon_q[0].d !== 32'(k)) begin
                mismatched++;
                $display("FAIL header%0d: got %0d beats, header %h, expected %0d beats header %h",
                         k, mon_q.size(), (mon_q.size() > 0) ? mon_q[0].d : 32'hx, NB, 32'(k));
            end
            for (int j = 0; j < NB && j < mon_q.size(); j++) begin
                compared++;
                if (mon_q[j] !== exp_q[j]) begin
                    mismatched++;
                    $display("FAIL header%0d_beat%0d: got %h expected %h", k, j, mon_q[j], exp_q[j]);
                end
            end
            $display("header record %0d: seq beat %h", k, (mon_q.size() > 0) ? mon_q[0].d : 32'hx);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_record();
        test_pc_step();
        test_ready_toggle();
        test_trace_enable();
        test_reset_mid_record();
        test_random_records();
`ifdef TRACE_HEADER_EN
        test_header();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded 2 ms, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
